// File: rtl/sequence_generator.sv
// rtl/sequence_generator.sv - serial pattern transmitter with repeat, idle gap and pattern counter
module sequence_generator #(
  parameter int WIDTH     = 6,
  parameter int CNT_WIDTH = 6,
  parameter int REP_WIDTH = 4,
  parameter int GAP_WIDTH = 3
) (
  input  logic                 clk_gate,
  input  logic                 i_resetn,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [WIDTH-1:0]     i_pattern,
  input  logic [REP_WIDTH-1:0] i_repeat,
  input  logic [GAP_WIDTH-1:0] i_gap,
  output logic                 o_ready,
  output logic                 o_data,
  output logic                 o_data_valid,
  output logic                 o_frame_last,
  output logic                 o_done,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic                 o_count_end
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [REP_WIDTH-1:0] REP_ONE  = REP_WIDTH'(1);
  localparam logic [GAP_WIDTH-1:0] GAP_ONE  = GAP_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     shreg_q, shreg_d;
  logic [WIDTH-1:0]     pattern_q, pattern_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [REP_WIDTH-1:0] rep_left_q, rep_left_d;
  logic [GAP_WIDTH-1:0] gap_q, gap_d;
  logic [GAP_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 last_bit;

  assign last_bit = (state_q == S_SHIFT) && (bit_idx_q == LAST_IDX);

  // State and datapath registers; reset clears everything, abandoning any frame in flight.
  always_ff @(posedge clk_gate or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      pattern_q  <= '0;
      bit_idx_q  <= '0;
      rep_left_q <= '0;
      gap_q      <= '0;
      gap_cnt_q  <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      pattern_q  <= pattern_d;
      bit_idx_q  <= bit_idx_d;
      rep_left_q <= rep_left_d;
      gap_q      <= gap_d;
      gap_cnt_q  <= gap_cnt_d;
      count_q    <= count_d;
    end
  end

  // Next-state logic: capture on accept, shift MSB-first, reload per repetition, honour abort.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    pattern_d  = pattern_q;
    bit_idx_d  = bit_idx_q;
    rep_left_d = rep_left_q;
    gap_d      = gap_q;
    gap_cnt_d  = gap_cnt_q;
    count_d    = count_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          pattern_d  = i_pattern;
          shreg_d    = i_pattern;
          rep_left_d = i_repeat;
          gap_d      = i_gap;
          bit_idx_d  = '0;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shreg_d   = shreg_q << 1;
        bit_idx_d = bit_idx_q + IDX_ONE;
        if (last_bit) begin
          // A completed pattern is counted even if abort arrives on the same edge.
          count_d   = count_q + CNT_ONE;
          bit_idx_d = '0;
          shreg_d   = pattern_q;
          if (rep_left_q == '0) begin
            state_d = S_DONE;
          end else begin
            rep_left_d = rep_left_q - REP_ONE;
            if (gap_q == '0) begin
              state_d = S_SHIFT;
            end else begin
              state_d   = S_GAP;
              gap_cnt_d = gap_q;
            end
          end
        end
        if (i_abort) begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q - GAP_ONE;
        if (gap_cnt_q == GAP_ONE) begin
          state_d = S_SHIFT;
        end
        if (i_abort) begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_ready      = (state_q == S_IDLE);
  assign o_data_valid = (state_q == S_SHIFT);
  assign o_data       = o_data_valid & shreg_q[WIDTH-1];
  assign o_frame_last = last_bit;
  assign o_done       = (state_q == S_DONE);
  assign o_count      = count_q;
  assign o_count_end  = &count_q;

endmodule
